ntt_addr_seq: RTL
=================

# ntt_addr_seq

Self-sequencing NTT/INTT address generator for the VP vector unit. It replaces the externally counted shared address generator. It owns its own stage/cycle counter, takes the transform size as a runtime `logN`, and presents each butterfly slot's shared addresses on a valid/ready handshake. It sits between the VP instruction issue logic and the per-lane VRF/twiddle-ROM read/write ports.

## Interface
Parameters:
- `NLANE`, 32: lane count, power of two ≥ 4; `H = log2(NLANE/2)`.
- `ADDR_WIDTH`, 32: VRF address width.
- `TF_ADDR_WIDTH`, 32: twiddle address width.
- `TF_ITEM_NUM`, 3: twiddle tables; `TFID_W = clog2(TF_ITEM_NUM)`.
- `LOGN_MIN`, 10 / `LOGN_MAX`, 16: legal transform sizes; `LOGN_MIN ≥ log2(NLANE)+1`.
- Derived: `SMAX = LOGN_MAX - log2(NLANE)`; `CNT_W = clog2(LOGN_MAX) + SMAX`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `i_start`, in, 1: launch a transform; ignored unless IDLE.
- `i_abort`, in, 1: return to IDLE next cycle; no done.
- `i_ntt_mode`, in, 1: 1 = NTT, 0 = INTT; sampled at start.
- `i_logn`, in, 5: log2 of points per lane-set; sampled at start.
- `i_tf_item_id`, in, TFID_W: twiddle table; sampled at start.
- `o_valid`, out, 1: address slot valid.
- `i_ready`, in, 1: consumer accepts the slot.
- `o_raddr` / `o_waddr`, out, ADDR_WIDTH: shared VRF read / write address.
- `o_tfaddr`, out, TF_ADDR_WIDTH: shared twiddle address.
- `o_rw_vrf_swap`, `o_alu_inout_swap`, out, 1: `hb[0]`, `lb[0]`; 0 when not valid.
- `o_stage`, out, clog2(LOGN_MAX): current stage `hb`.
- `o_last`, out, 1: slot is the final one of the transform.
- `o_busy`, out, 1: not IDLE.
- `o_done`, out, 1: one-cycle pulse after the last slot is accepted.
- `o_err`, out, 1: one-cycle pulse on rejected start.
- `o_total_cyc`, out, CNT_W+1: `S_CYC*logN` for the latched config.

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN on `i_start` with `LOGN_MIN ≤ i_logn ≤ LOGN_MAX`. An out-of-range start stays in IDLE and pulses `o_err`.
- RUN→DONE when the `o_last` slot is accepted (`o_valid & i_ready`). DONE→IDLE unconditionally; `o_done` is high in DONE.
- `i_abort` from any state → IDLE; abort has priority over start and accept.
- Config latched at start: `S = logN - log2(NLANE)`, `S_CYC = 2^S`, mode, table id.
- Counter `cnt` is cleared at start and advances only on accept. `lb = cnt[S-1:0]`, `hb = cnt >> S`, `rlb = S_CYC-1-lb`.
- `ROT(x) = (x>>1) | (x[0]<<(S-1))`: rotate right over S bits.
- NTT: raddr = `ROT(lb)`, waddr = `lb`.
- INTT: raddr = `rlb`, waddr = `ROT(rlb)`.
- NTT twiddle `t`:
  - `hb < H`: `t = hb`.
  - else with `k = hb-H`: `t = 2^k + (lb & (2^k-1)) + H - 1`.
- INTT twiddle, with `B = 1<<(TF_ADDR_WIDTH-1-TFID_W)`:
  - `hb ≥ logN-H`: `t = logN-hb-1 + B`.
  - else with `k = logN-1-H-hb`: `t = 2^k + (rlb & (2^k-1)) + H - 1 + B`.
- `o_tfaddr = (tf_id << (TF_ADDR_WIDTH-TFID_W)) | t`.
- Addresses are zero-extended; arithmetic is unsigned and never wraps for legal logN.
- `o_last = (hb == logN-1) & (lb == S_CYC-1)`.

## Timing
- Reset: all outputs 0, state IDLE, `cnt` 0.
- Start in cycle T: `o_busy` and `o_valid` are high at T+1 with the slot for `cnt = 0`.
- All address outputs are registered. The next slot appears the cycle after an accept, giving one slot per cycle at `i_ready = 1`.
- While `o_valid & !i_ready`, every output holds stable.
- Total accepted slots = `o_total_cyc = S_CYC*logN`; `o_total_cyc` is valid from T+1.
- `o_done` is asserted the cycle after the last accept. `o_busy` falls with `o_done`, so a new start is accepted in the `o_done` cycle + 1.
- Abort at T: `o_valid`, `o_busy`, and swaps are 0 at T+1; addresses are held; no `o_done`.
- `rst_n` low mid-run: immediate asynchronous clear; no done, no err.

## Test plan
- NLANE=32, NTT, logN=10, ready=1:
  - 320 slots, then `o_done` once.
  - cnt=1 → raddr 16, waddr 1, tf 0, alu_swap 1.
  - cnt=163 → stage 5, tf 6.
- INTT, logN=10, TF_ADDR_WIDTH=12, item 1:
  - cnt=0 → raddr 31, waddr 31, tf 1602.
  - first slot of stage 9 → tf 1536.
- Backpressure: random `i_ready` at 30%. Outputs stable while stalled; accepted sequence identical to the ready=1 run; total still 320.
- Config edges:
  - `i_logn = 9`: `o_err` pulse, stays IDLE.
  - `i_logn = 16`: `o_total_cyc = 32768`; `o_last` only on the final slot.
  - start while busy: ignored.
- Abort at slot 100: idle next cycle, no done. A restart then begins at cnt 0.
- Async reset asserted mid-run between clock edges: outputs 0 immediately; a clean transform follows.

Source files
------------

// File: rtl/ntt_addr_seq.sv
// Purpose : self-sequencing NTT/INTT butterfly address generator (VRF read/write + twiddle).
// Latency : first slot valid the cycle after an accepted start; one slot per cycle at full ready.
// Backpr. : valid/ready; the slot and every output hold while o_valid & !i_ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_start/i_abort          launch (IDLE only) / return to IDLE, abort wins over everything
//   i_ntt_mode/i_logn/i_tf_item_id   transform config, latched on an accepted start
//   o_valid/i_ready          slot handshake
//   o_raddr/o_waddr/o_tfaddr shared VRF read/write and twiddle addresses (registered)
//   o_rw_vrf_swap/o_alu_inout_swap   hb[0] / lb[0] of the slot, 0 when no slot is valid
//   o_stage/o_last           current stage and final-slot flag
//   o_busy/o_done/o_err      not idle / one-cycle completion / one-cycle rejected start
//   o_total_cyc              slot count of the latched transform (S_CYC * logN)
module ntt_addr_seq #(
    parameter int NLANE          = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TF_ADDR_WIDTH  = 32,
    parameter int TF_ITEM_NUM    = 3,
    parameter int LOGN_MIN       = 10,
    parameter int LOGN_MAX       = 16,
    localparam int TFID_W        = $clog2(TF_ITEM_NUM),
    localparam int STG_W         = $clog2(LOGN_MAX),
    localparam int SMAX          = LOGN_MAX - $clog2(NLANE),
    localparam int CNT_W         = $clog2(LOGN_MAX) + SMAX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_ntt_mode,
    input  logic [4:0]               i_logn,
    input  logic [TFID_W-1:0]        i_tf_item_id,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ADDR_WIDTH-1:0]    o_raddr,
    output logic [ADDR_WIDTH-1:0]    o_waddr,
    output logic [TF_ADDR_WIDTH-1:0] o_tfaddr,
    output logic                     o_rw_vrf_swap,
    output logic                     o_alu_inout_swap,
    output logic [STG_W-1:0]         o_stage,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [CNT_W:0]           o_total_cyc
);

    localparam int LG_NL = $clog2(NLANE);
    localparam int H     = $clog2(NLANE / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // latched configuration
    logic [4:0]               logn_q;
    logic                     mode_q;
    logic [TFID_W-1:0]        tfid_q;
    logic [CNT_W-1:0]         cnt_q;

    // registered slot
    logic [ADDR_WIDTH-1:0]    raddr_q, waddr_q;
    logic [TF_ADDR_WIDTH-1:0] tfaddr_q;
    logic                     rsw_q, asw_q, last_q, err_q;
    logic [STG_W-1:0]         stage_q;
    logic [CNT_W:0]           total_q;

    // control
    logic                     logn_legal, start_ok, accept, last_acc;
    logic [CNT_W-1:0]         cnt_d;

    // config seen by the slot generator: live inputs while idle so the first slot
    // can be registered in the same edge that latches the config
    logic [4:0]               logn_c, s_c;
    logic                     mode_c;
    logic [TFID_W-1:0]        tfid_c;

    // slot generator
    logic [CNT_W-1:0]         smask, lb, hb, rlb, rot_lb, rot_rlb, raddr_c, waddr_c;
    logic [TF_ADDR_WIDTH-1:0] t_c, kmask, base_b, tfaddr_c;
    logic [4:0]               k;
    logic                     last_c;
    logic [CNT_W:0]           total_d;

    assign logn_legal = (i_logn >= 5'(LOGN_MIN)) && (i_logn <= 5'(LOGN_MAX));
    assign start_ok   = (state_q == ST_IDLE) && i_start && !i_abort && logn_legal;
    assign accept     = (state_q == ST_RUN) && i_ready && !i_abort;
    assign last_acc   = accept && last_q;

    assign cnt_d  = start_ok ? '0 : (accept ? cnt_q + CNT_W'(1) : cnt_q);

    assign logn_c = (state_q == ST_IDLE) ? i_logn       : logn_q;
    assign mode_c = (state_q == ST_IDLE) ? i_ntt_mode   : mode_q;
    assign tfid_c = (state_q == ST_IDLE) ? i_tf_item_id : tfid_q;
    assign s_c    = logn_c - 5'(LG_NL);

    // Addresses for the slot that cnt_d selects.
    always_comb begin
        smask   = ~({CNT_W{1'b1}} << s_c);
        lb      = cnt_d & smask;
        hb      = cnt_d >> s_c;
        rlb     = smask - lb;
        // rotate right by one inside an S-bit field
        rot_lb  = (lb  >> 1) | ((lb  & CNT_W'(1)) << (s_c - 5'd1));
        rot_rlb = (rlb >> 1) | ((rlb & CNT_W'(1)) << (s_c - 5'd1));
        base_b  = TF_ADDR_WIDTH'(1) << (TF_ADDR_WIDTH - 1 - TFID_W);
        k       = '0;
        kmask   = '0;
        t_c     = '0;
        raddr_c = '0;
        waddr_c = '0;
        if (mode_c) begin
            raddr_c = rot_lb;
            waddr_c = lb;
            if (hb < CNT_W'(H)) begin
                t_c = TF_ADDR_WIDTH'(hb);
            end else begin
                k     = 5'(hb - CNT_W'(H));
                kmask = ~({TF_ADDR_WIDTH{1'b1}} << k);
                t_c   = (kmask + TF_ADDR_WIDTH'(1)) + (TF_ADDR_WIDTH'(lb) & kmask)
                        + TF_ADDR_WIDTH'(H - 1);
            end
        end else begin
            raddr_c = rlb;
            waddr_c = rot_rlb;
            if (hb >= CNT_W'(logn_c) - CNT_W'(H)) begin
                t_c = TF_ADDR_WIDTH'(CNT_W'(logn_c) - hb - CNT_W'(1)) + base_b;
            end else begin
                k     = 5'(CNT_W'(logn_c) - CNT_W'(1 + H) - hb);
                kmask = ~({TF_ADDR_WIDTH{1'b1}} << k);
                t_c   = (kmask + TF_ADDR_WIDTH'(1)) + (TF_ADDR_WIDTH'(rlb) & kmask)
                        + TF_ADDR_WIDTH'(H - 1) + base_b;
            end
        end
        tfaddr_c = (TF_ADDR_WIDTH'(tfid_c) << (TF_ADDR_WIDTH - TFID_W)) | t_c;
        last_c   = (hb == CNT_W'(logn_c) - CNT_W'(1)) && (lb == smask);
        total_d  = (CNT_W + 1)'(logn_c) << s_c;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok) state_d = ST_RUN;
                ST_RUN:  if (last_acc) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        o_valid = (state_q == ST_RUN);
        o_busy  = (state_q != ST_IDLE);
        o_done  = (state_q == ST_DONE);
    end

    // counter, config and slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            logn_q   <= '0;
            mode_q   <= 1'b0;
            tfid_q   <= '0;
            total_q  <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            tfaddr_q <= '0;
            rsw_q    <= 1'b0;
            asw_q    <= 1'b0;
            stage_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && i_start && !i_abort && !logn_legal;
            if (!i_abort) begin
                cnt_q <= cnt_d;
            end
            if (start_ok) begin
                logn_q  <= i_logn;
                mode_q  <= i_ntt_mode;
                tfid_q  <= i_tf_item_id;
                total_q <= total_d;
            end
            // addresses are held once no slot is valid; only the per-slot flags drop
            if (i_abort || last_acc) begin
                rsw_q  <= 1'b0;
                asw_q  <= 1'b0;
                last_q <= 1'b0;
            end else if (start_ok || accept) begin
                raddr_q  <= ADDR_WIDTH'(raddr_c);
                waddr_q  <= ADDR_WIDTH'(waddr_c);
                tfaddr_q <= tfaddr_c;
                rsw_q    <= hb[0];
                asw_q    <= lb[0];
                stage_q  <= STG_W'(hb);
                last_q   <= last_c;
            end
        end
    end

    assign o_raddr          = raddr_q;
    assign o_waddr          = waddr_q;
    assign o_tfaddr         = tfaddr_q;
    assign o_rw_vrf_swap    = rsw_q;
    assign o_alu_inout_swap = asw_q;
    assign o_stage          = stage_q;
    assign o_last           = last_q;
    assign o_err            = err_q;
    assign o_total_cyc      = total_q;

endmodule
